// File: rtl/led_stream_receiver_pkg.sv
// Shared types and constants for the LED stream receiver.
package CCHW;

  localparam int LED_BITS_PER_PIXEL = 24;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } RGB;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_t;

endpackage

// File: rtl/led_stream_receiver_sync_edge.sv
// Two-flop synchronizer with an optional rising-edge detector.
// The data path uses the same synchronizer depth as the clock path
// so that a sampled bit lines up with the edge that qualifies it.
module SyncEdge #(
  parameter bit EDGE_DET = 1'b1
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_sync,
  output logic o_rise
);

  logic [1:0] r_sync;

  // Two-stage metastability synchronizer.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= 2'b00;
    else          r_sync <= {r_sync[0], i_d};
  end

  assign o_sync = r_sync[1];

  generate
    if (EDGE_DET) begin : g_edge
      logic r_hist;
      // History flop: previous synchronized level for edge detection.
      always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) r_hist <= 1'b0;
        else          r_hist <= r_sync[1];
      end
      assign o_rise = r_sync[1] & ~r_hist;
    end else begin : g_noedge
      assign o_rise = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/led_stream_receiver.sv
// Captures a serial LED stream (ledClock/ledData) into 24-bit RGB pixels
// and reports per-frame statistics when the stream goes quiet.
module led_stream_receiver
  import CCHW::*;
#(
  parameter int LEDS        = 50,
  parameter int IDLE_CYCLES = 25000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ledClock,
  input  logic                       ledData,
  output logic [23:0]                pixel,
  output logic [$clog2(LEDS)-1:0]    pixelIndex,
  output logic                       pixelValid,
  output logic                       frameDone,
  output logic [$clog2(LEDS+1)-1:0]  ledCount,
  output logic                       overflow,
  output logic                       partial
);

  localparam int IDX_W  = $clog2(LEDS);
  localparam int CNT_W  = $clog2(LEDS+1);
  localparam int IDLE_W = $clog2(IDLE_CYCLES+1);
  localparam logic [CNT_W-1:0]  LEDS_C   = CNT_W'(LEDS);
  localparam logic [IDLE_W-1:0] IDLE_C   = IDLE_W'(IDLE_CYCLES);
  localparam logic [4:0]        LAST_BIT = 5'(LED_BITS_PER_PIXEL - 1);

  logic              w_clk_sync_unused;
  logic              w_clk_rise;
  logic              w_data_sync;
  logic              w_data_rise_unused;
  logic              r_rise_p1;
  logic              r_data_p1;
  rx_state_t         r_state;
  rx_state_t         w_state_next;
  logic              w_timeout;
  logic [IDLE_W-1:0] r_idle_cnt;
  // Holds the first 23 bits of a pixel; the 24th joins directly on completion.
  logic [22:0]       r_shift;
  logic [23:0]       w_shift_next;
  logic [4:0]        r_bit_cnt;
  logic [CNT_W-1:0]  r_pix_cnt;
  logic              r_ovf_acc;
  RGB                r_pixel;

  SyncEdge #(.EDGE_DET(1'b1)) u_sync_clk (
    .clk     (clk),
    .i_rst_n (rst),
    .i_d     (ledClock),
    .o_sync  (w_clk_sync_unused),
    .o_rise  (w_clk_rise)
  );

  SyncEdge #(.EDGE_DET(1'b0)) u_sync_data (
    .clk     (clk),
    .i_rst_n (rst),
    .i_d     (ledData),
    .o_sync  (w_data_sync),
    .o_rise  (w_data_rise_unused)
  );

  // Stage p1: register the detected edge with its aligned data bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rise_p1 <= 1'b0;
      r_data_p1 <= 1'b0;
    end else begin
      r_rise_p1 <= w_clk_rise;
      r_data_p1 <= w_data_sync;
    end
  end

  // Frame state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  // Next state; an edge coinciding with the timeout keeps the frame alive.
  always_comb begin
    w_state_next = r_state;
    w_timeout    = 1'b0;
    case (r_state)
      IDLE: if (r_rise_p1) w_state_next = RECV;
      RECV: if (!r_rise_p1 && (r_idle_cnt == IDLE_C)) begin
        w_state_next = IDLE;
        w_timeout    = 1'b1;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Quiet-time counter: cleared by edges, saturating, runs only in RECV.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_idle_cnt <= '0;
    else if (r_rise_p1)
      r_idle_cnt <= '0;
    else if ((r_state == RECV) && (r_idle_cnt != IDLE_C))
      r_idle_cnt <= r_idle_cnt + 1'b1;
  end

  assign w_shift_next = {r_shift, r_data_p1};
  assign pixel        = r_pixel;

  // Stage p2: shift bits in, emit completed pixels, close frames on timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_pix_cnt  <= '0;
      r_ovf_acc  <= 1'b0;
      r_pixel    <= '0;
      pixelIndex <= '0;
      pixelValid <= 1'b0;
      frameDone  <= 1'b0;
      ledCount   <= '0;
      overflow   <= 1'b0;
      partial    <= 1'b0;
    end else begin
      pixelValid <= 1'b0;
      frameDone  <= 1'b0;
      if (w_timeout) begin
        frameDone <= 1'b1;
        ledCount  <= (r_pix_cnt > LEDS_C) ? LEDS_C : r_pix_cnt;
        overflow  <= r_ovf_acc;
        partial   <= (r_bit_cnt != '0);
        r_shift   <= '0;
        r_bit_cnt <= '0;
        r_pix_cnt <= '0;
        r_ovf_acc <= 1'b0;
      end else if (r_rise_p1) begin
        r_shift <= w_shift_next[22:0];
        if (r_bit_cnt == LAST_BIT) begin
          r_bit_cnt <= '0;
          if (r_pix_cnt == LEDS_C) begin
            r_ovf_acc <= 1'b1;
          end else begin
            r_pixel    <= RGB'(w_shift_next);
            pixelIndex <= r_pix_cnt[IDX_W-1:0];
            pixelValid <= 1'b1;
            r_pix_cnt  <= r_pix_cnt + 1'b1;
          end
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_led_stream_receiver.sv
// Directed bench for led_stream_receiver with a behavioural LED driver.
module tb_led_stream_receiver;

  localparam int LEDS     = 4;
  localparam int IDLE     = 64;
  localparam int FREQ_DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ledClock;
  logic        ledData;
  logic [23:0] pixel;
  logic [1:0]  pixelIndex;
  logic        pixelValid;
  logic        frameDone;
  logic [2:0]  ledCount;
  logic        overflow;
  logic        partial;

  int checks = 0;
  int errors = 0;

  logic [23:0] q_px[$];
  int          q_idx[$];
  int          fd_cnt[$];
  logic        fd_ovf[$];
  logic        fd_part[$];
  int          n_overlap = 0;

  led_stream_receiver #(.LEDS(LEDS), .IDLE_CYCLES(IDLE)) dut (
    .clk        (clk),
    .rst        (rst),
    .ledClock   (ledClock),
    .ledData    (ledData),
    .pixel      (pixel),
    .pixelIndex (pixelIndex),
    .pixelValid (pixelValid),
    .frameDone  (frameDone),
    .ledCount   (ledCount),
    .overflow   (overflow),
    .partial    (partial)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pixelValid) begin
      q_px.push_back(pixel);
      q_idx.push_back(int'(pixelIndex));
    end
    if (frameDone) begin
      fd_cnt.push_back(int'(ledCount));
      fd_ovf.push_back(overflow);
      fd_part.push_back(partial);
    end
    if (pixelValid && frameDone) n_overlap++;
  end

  typedef struct {
    int           nbits;
    logic [143:0] tx;
    int           exp_nv;
    logic [143:0] exp_px;
    int           exp_cnt;
    logic         exp_ovf;
    logic         exp_part;
  } vec_t;

  vec_t vecs[4];

  function automatic logic [143:0] pack6(input logic [23:0] p0, p1, p2, p3, p4, p5);
    return {p5, p4, p3, p2, p1, p0};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic clear_logs();
    q_px.delete(); q_idx.delete();
    fd_cnt.delete(); fd_ovf.delete(); fd_part.delete();
  endtask

  // Driver: data changes with the falling ledClock, rises FREQ_DIV clk later.
  task automatic send_bit(input logic b);
    ledData  = b;
    ledClock = 1'b0;
    repeat (FREQ_DIV) @(posedge clk);
    #1;
    ledClock = 1'b1;
    repeat (FREQ_DIV) @(posedge clk);
    #1;
  endtask

  task automatic send_stream(input logic [143:0] tx, input int nbits);
    for (int i = 0; i < nbits; i++)
      send_bit(tx[(i / 24) * 24 + 23 - (i % 24)]);
  endtask

  // Pads so that consecutive ledClock rises are n clk cycles apart.
  task automatic gap(input int n);
    ledClock = 1'b0;
    repeat (n - 2 * FREQ_DIV) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    repeat (IDLE + 16) @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_pixel"},      32'(pixel),      32'h0);
    check({tag, "_index"},      32'(pixelIndex), 32'h0);
    check({tag, "_valid"},      32'(pixelValid), 32'h0);
    check({tag, "_done"},       32'(frameDone),  32'h0);
    check({tag, "_ledCount"},   32'(ledCount),   32'h0);
    check({tag, "_overflow"},   32'(overflow),   32'h0);
    check({tag, "_partial"},    32'(partial),    32'h0);
  endtask

  initial begin
    vecs[0] = '{72, pack6(24'hFF0000, 24'h00FF00, 24'h123456, 24'h0, 24'h0, 24'h0),
                3, pack6(24'hFF0000, 24'h00FF00, 24'h123456, 24'h0, 24'h0, 24'h0), 3, 1'b0, 1'b0};
    vecs[1] = '{30, pack6(24'hA5C3E1, 24'hFC0000, 24'h0, 24'h0, 24'h0, 24'h0),
                1, pack6(24'hA5C3E1, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0), 1, 1'b0, 1'b1};
    vecs[2] = '{144, pack6(24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C, 24'h0D0E0F, 24'h101112),
                4, pack6(24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C, 24'h0, 24'h0), 4, 1'b1, 1'b0};
    vecs[3] = '{96, pack6(24'hDEADBE, 24'h0F1E2D, 24'h800001, 24'h7FFFFE, 24'h0, 24'h0),
                4, pack6(24'hDEADBE, 24'h0F1E2D, 24'h800001, 24'h7FFFFE, 24'h0, 24'h0), 4, 1'b0, 1'b0};

    rst      = 1'b0;
    ledClock = 1'b0;
    ledData  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Table-driven frames: basic, partial, overflow, driver loopback.
    for (int v = 0; v < 4; v++) begin
      clear_logs();
      send_stream(vecs[v].tx, vecs[v].nbits);
      wait_idle();
      check($sformatf("v%0d_nvalid", v), 32'(q_px.size()), 32'(vecs[v].exp_nv));
      for (int k = 0; k < vecs[v].exp_nv; k++) begin
        if (k < q_px.size()) begin
          check($sformatf("v%0d_px%0d", v, k), 32'(q_px[k]), 32'(vecs[v].exp_px[k*24 +: 24]));
          check($sformatf("v%0d_idx%0d", v, k), 32'(q_idx[k]), 32'(k));
        end
      end
      check($sformatf("v%0d_ndone", v), 32'(fd_cnt.size()), 32'd1);
      if (fd_cnt.size() > 0) begin
        check($sformatf("v%0d_ledCount", v), 32'(fd_cnt[0]), 32'(vecs[v].exp_cnt));
        check($sformatf("v%0d_overflow", v), 32'(fd_ovf[0]), 32'(vecs[v].exp_ovf));
        check($sformatf("v%0d_partial", v), 32'(fd_part[0]), 32'(vecs[v].exp_part));
      end
      check($sformatf("v%0d_held_cnt", v), 32'(ledCount), 32'(vecs[v].exp_cnt));
      check($sformatf("v%0d_held_ovf", v), 32'(overflow), 32'(vecs[v].exp_ovf));
    end

    // Latency of pixelValid relative to the 24th ledClock rise.
    clear_logs();
    begin
      logic [23:0] p;
      p = 24'hABCDEF;
      for (int i = 0; i < 23; i++) send_bit(p[23 - i]);
      ledData  = p[0];
      ledClock = 1'b0;
      repeat (FREQ_DIV) @(posedge clk);
      #1;
      ledClock = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("latency_before", 32'(pixelValid), 32'd0);
      @(posedge clk);
      #1;
      check("latency_at3", 32'(pixelValid), 32'd1);
      check("latency_pixel", 32'(pixel), 32'hABCDEF);
      repeat (FREQ_DIV - 4) @(posedge clk);
      wait_idle();
      check("latency_ndone", 32'(fd_cnt.size()), 32'd1);
    end

    // Reset in the middle of a frame discards it.
    clear_logs();
    send_stream(pack6(24'hFFF000, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0), 12);
    rst      = 1'b0;
    ledClock = 1'b0;
    ledData  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("midrst");
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    send_stream(pack6(24'h5A5A5A, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0), 24);
    wait_idle();
    check("midrst_nvalid", 32'(q_px.size()), 32'd1);
    if (q_px.size() > 0) begin
      check("midrst_px", 32'(q_px[0]), 32'h5A5A5A);
      check("midrst_idx", 32'(q_idx[0]), 32'd0);
    end
    check("midrst_ndone", 32'(fd_cnt.size()), 32'd1);
    if (fd_cnt.size() > 0) begin
      check("midrst_cnt", 32'(fd_cnt[0]), 32'd1);
      check("midrst_part", 32'(fd_part[0]), 32'd0);
    end

    // Gap just under the timeout: one merged frame.
    clear_logs();
    send_stream(pack6(24'h111111, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0), 24);
    gap(IDLE - 1);
    send_stream(pack6(24'h222222, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0), 24);
    wait_idle();
    check("gapshort_ndone", 32'(fd_cnt.size()), 32'd1);
    if (fd_cnt.size() > 0) check("gapshort_cnt", 32'(fd_cnt[0]), 32'd2);
    check("gapshort_nvalid", 32'(q_px.size()), 32'd2);
    if (q_px.size() > 1) begin
      check("gapshort_idx1", 32'(q_idx[1]), 32'd1);
      check("gapshort_px1", 32'(q_px[1]), 32'h222222);
    end

    // Gap beyond the timeout: two separate frames.
    clear_logs();
    send_stream(pack6(24'h333333, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0), 24);
    gap(IDLE + 4);
    send_stream(pack6(24'h444444, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0), 24);
    wait_idle();
    check("gaplong_ndone", 32'(fd_cnt.size()), 32'd2);
    if (fd_cnt.size() > 1) begin
      check("gaplong_cnt0", 32'(fd_cnt[0]), 32'd1);
      check("gaplong_cnt1", 32'(fd_cnt[1]), 32'd1);
    end
    check("gaplong_nvalid", 32'(q_px.size()), 32'd2);
    if (q_px.size() > 1) begin
      check("gaplong_idx1", 32'(q_idx[1]), 32'd0);
      check("gaplong_px1", 32'(q_px[1]), 32'h444444);
    end

    check("valid_done_overlap", 32'(n_overlap), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
